// File: rtl/texture_store.sv
// texture_store: texel memory for the pixel cluster.
// Lookups return the texel one cycle after the index is presented; indices at or
// beyond DEPTH return DEFAULT_COLOR. A load port streams texels in under a
// small IDLE/LOAD FSM that wraps the write pointer and clamps the length.
//
// Load handshake: a texel transfers on every rising edge where
// load_valid && load_ready. The store raises load_ready for the whole time it
// is in LOAD, independent of load_valid. The source may drop load_valid for any
// number of cycles, which simply pauses the load. load_data is sampled only on
// transfer edges.
module texture_store #(
  parameter int                     INDEX_WIDTH   = 32,
  parameter int                     COLOR_WIDTH   = 12,
  parameter int                     DEPTH         = 256,
  parameter logic [COLOR_WIDTH-1:0] DEFAULT_COLOR = '1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic [INDEX_WIDTH-1:0] load_base,
  input  logic [INDEX_WIDTH-1:0] load_len,
  input  logic                   load_valid,
  input  logic [COLOR_WIDTH-1:0] load_data,
  output logic                   load_ready,
  output logic                   load_done,
  output logic                   busy,
  input  logic [INDEX_WIDTH-1:0] mem_index,
  output logic [COLOR_WIDTH-1:0] mem_color
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int REM_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  logic [COLOR_WIDTH-1:0] mem [DEPTH];

  state_t           state, state_next;
  logic [PTR_W-1:0] ptr, ptr_next;
  logic [REM_W-1:0] remaining, remaining_next;
  logic             done_next;
  logic             wr_en;

  logic [REM_W-1:0] len_clamped;
  logic [PTR_W-1:0] base_wrapped;

  // Length is compared at full width before narrowing, so huge lengths clamp
  // to DEPTH instead of aliasing to a small count.
  assign len_clamped  = (load_len > INDEX_WIDTH'(DEPTH)) ? REM_W'(DEPTH) : REM_W'(load_len);
  assign base_wrapped = PTR_W'(load_base % INDEX_WIDTH'(DEPTH));

  assign busy       = (state == LOAD);
  assign load_ready = (state == LOAD);

  // State, pointer, count and done-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      remaining <= remaining_next;
      load_done <= done_next;
    end
  end

  // Next-state logic: start/clamp in IDLE, accept-and-advance in LOAD.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    remaining_next = remaining;
    done_next      = 1'b0;
    wr_en          = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          ptr_next       = base_wrapped;
          remaining_next = len_clamped;
          if (len_clamped == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (load_valid) begin
          wr_en          = 1'b1;
          ptr_next       = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
          remaining_next = remaining - 1'b1;
          if (remaining == REM_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Texel write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr] <= load_data;
    end
  end

  // Registered lookup; a same-cycle write to the same address returns the old texel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_color <= DEFAULT_COLOR;
    end else if (mem_index < INDEX_WIDTH'(DEPTH)) begin
      mem_color <= mem[mem_index[PTR_W-1:0]];
    end else begin
      mem_color <= DEFAULT_COLOR;
    end
  end

endmodule

// File: tb/tb_texture_store.sv
// Directed bench for texture_store: table-driven lookups plus hand-written
// load sequences (stall, wrap/clamp, zero length, collision, back-to-back,
// reset during load).
module tb_texture_store;

  typedef struct {
    logic [31:0] idx;
    logic [11:0] exp;
  } rd_vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [31:0] load_base;
  logic [31:0] load_len;
  logic        load_valid;
  logic [11:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        busy;
  logic [31:0] mem_index;
  logic [11:0] mem_color;

  int checks   = 0;
  int failures = 0;

  rd_vec_t     tbl[$];
  logic [11:0] exp_q[$];
  logic [11:0] data_q[$];
  bit          vpat[$];
  int          nwrites;

  texture_store dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .busy       (busy),
    .mem_index  (mem_index),
    .mem_color  (mem_color)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Present every index of tbl on consecutive cycles; scoreboard compares one cycle later.
  task automatic run_reads(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      logic [11:0] e;
      mem_index = tbl[i].idx;
      exp_q.push_back(tbl[i].exp);
      step();
      e = exp_q.pop_front();
      check($sformatf("%s_rd_idx_%h", tag, tbl[i].idx), 32'(mem_color), 32'(e));
    end
    tbl.delete();
  endtask

  // Drive a load from data_q with valid pattern vpat (1 after the pattern ends).
  task automatic do_load(input logic [31:0] base, input logic [31:0] len, output int writes);
    int rem;
    int cyc;
    int di;
    bit v;
    rem    = (len > 32'd256) ? 256 : int'(len);
    writes = 0;
    load_base  = base;
    load_len   = len;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_base  = $urandom;
    load_len   = $urandom;
    if (rem == 0) begin
      check("len0_busy", 32'(busy), 32'd0);
      check("len0_done", 32'(load_done), 32'd1);
      step();
      check("len0_done_end", 32'(load_done), 32'd0);
      check("len0_busy_after", 32'(busy), 32'd0);
      return;
    end
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(load_ready), 32'd1);
    cyc = 0;
    di  = 0;
    while (rem > 0 && cyc < 2000) begin
      v = (cyc < vpat.size()) ? vpat[cyc] : 1'b1;
      load_valid = v;
      load_data  = v ? data_q[di] : 12'($urandom);
      step();
      cyc++;
      if (v) begin
        di++;
        rem--;
        writes++;
      end
      if (rem == 0) begin
        check("end_done", 32'(load_done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_ready", 32'(load_ready), 32'd0);
      end else begin
        check("mid_done", 32'(load_done), 32'd0);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_ready", 32'(load_ready), 32'd1);
      end
    end
    if (rem > 0) check("load_timeout", 32'd0, 32'd1);
    load_valid = 1'b0;
    step();
    check("done_one_cycle", 32'(load_done), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_base  = '0;
    load_len   = '0;
    load_valid = 1'b0;
    load_data  = '0;
    mem_index  = '0;

    // Reset state.
    step();
    step();
    check("rst_color", 32'(mem_color), 32'hFFF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    rst_n = 1'b1;
    #2;
    check("rst_release_color", 32'(mem_color), 32'hFFF);
    step();
    check("rst_release_done", 32'(load_done), 32'd0);

    // Basic 4-texel load.
    data_q = '{12'h123, 12'h456, 12'h789, 12'hABC};
    vpat.delete();
    do_load(32'd0, 32'd4, nwrites);
    check("basic_writes", 32'(nwrites), 32'd4);
    tbl.push_back('{32'd0, 12'h123});
    tbl.push_back('{32'd1, 12'h456});
    tbl.push_back('{32'd2, 12'h789});
    tbl.push_back('{32'd3, 12'hABC});
    tbl.push_back('{32'd256, 12'hFFF});
    tbl.push_back('{32'hFFFF_FFFF, 12'hFFF});
    tbl.push_back('{32'd2, 12'h789});
    run_reads("basic");

    // Wrap and clamp: base 254, len 300, texel k = k.
    data_q.delete();
    for (int k = 0; k < 300; k++) data_q.push_back(12'(k));
    do_load(32'd254, 32'd300, nwrites);
    check("wrap_writes", 32'(nwrites), 32'd256);
    tbl.push_back('{32'd254, 12'h000});
    tbl.push_back('{32'd255, 12'h001});
    tbl.push_back('{32'd0, 12'h002});
    tbl.push_back('{32'd253, 12'h0FF});
    tbl.push_back('{32'd256, 12'hFFF});
    tbl.push_back('{32'hFFFF_FFFF, 12'hFFF});
    tbl.push_back('{32'd17, 12'h013});
    tbl.push_back('{32'd128, 12'h082});
    tbl.push_back('{32'h0000_0100 + 32'd17, 12'hFFF});
    run_reads("wrap");

    // Stalled load, random data on idle cycles must not be written.
    data_q = '{12'h321, 12'h654, 12'h987, 12'hCBA};
    vpat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_load(32'd0, 32'd4, nwrites);
    vpat.delete();
    check("stall_writes", 32'(nwrites), 32'd4);
    tbl.push_back('{32'd0, 12'h321});
    tbl.push_back('{32'd1, 12'h654});
    tbl.push_back('{32'd2, 12'h987});
    tbl.push_back('{32'd3, 12'hCBA});
    tbl.push_back('{32'd4, 12'h006});
    run_reads("stall");

    // Zero length, including a large base.
    do_load(32'd5, 32'd0, nwrites);
    do_load(32'h8000_0005, 32'd0, nwrites);

    // Read/write collision: old texel 12 at address 10 comes back first.
    mem_index  = 32'd10;
    load_base  = 32'd10;
    load_len   = 32'd1;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 12'h5A5;
    step();
    check("coll_old", 32'(mem_color), 32'h00C);
    check("coll_done", 32'(load_done), 32'd1);
    load_valid = 1'b0;
    step();
    check("coll_new", 32'(mem_color), 32'h5A5);
    check("coll_done_end", 32'(load_done), 32'd0);

    // load_start while load_done is high is honoured.
    load_base  = 32'd100;
    load_len   = 32'd1;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 12'h111;
    step();
    check("b2b_done1", 32'(load_done), 32'd1);
    load_valid = 1'b0;
    load_base  = 32'd101;
    load_len   = 32'd1;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(load_done), 32'd0);
    load_valid = 1'b1;
    load_data  = 12'h222;
    step();
    check("b2b_done2", 32'(load_done), 32'd1);
    load_valid = 1'b0;
    step();
    tbl.push_back('{32'd100, 12'h111});
    tbl.push_back('{32'd101, 12'h222});
    tbl.push_back('{32'd10, 12'h5A5});
    run_reads("b2b");

    // Reset after 2 of 4 writes: 40..41 new, 42..43 keep 0x02C/0x02D.
    load_base  = 32'd40;
    load_len   = 32'd4;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 12'hAAA;
    step();
    load_data  = 12'hBBB;
    step();
    check("rstmid_busy_before", 32'(busy), 32'd1);
    load_data = 12'hCCC;
    rst_n     = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_ready", 32'(load_ready), 32'd0);
    check("rstmid_done", 32'(load_done), 32'd0);
    check("rstmid_color", 32'(mem_color), 32'hFFF);
    step();
    load_valid = 1'b0;
    rst_n      = 1'b1;
    step();
    check("rstmid_after_busy", 32'(busy), 32'd0);
    check("rstmid_after_done", 32'(load_done), 32'd0);
    step();
    check("rstmid_after_done2", 32'(load_done), 32'd0);
    tbl.push_back('{32'd40, 12'hAAA});
    tbl.push_back('{32'd41, 12'hBBB});
    tbl.push_back('{32'd42, 12'h02C});
    tbl.push_back('{32'd43, 12'h02D});
    run_reads("rstmid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
